seg7_scan_driver: RTL and testbench

- Downstream consumer of the 16-bit digit word produced by the display output modifiers, such as the flicker stage.
- Time-multiplexes four 4-bit digit codes onto one common-segment 7-segment display. Decodes each code to segment patterns and drives per-digit anodes with inter-digit dead time.
- Snapshots the input once per frame, so the displayed digits never mix two words.

---
 rtl/seg7_scan_driver.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver: per-frame snapshot, hex-style decode, anode dead time.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
    parameter int unsigned CLK_FREQ    = 50000000,
    parameter int unsigned SCAN_FREQ   = 1000,
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic        enable,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int unsigned DIV   = CLK_FREQ / SCAN_FREQ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);

    generate
        if (DIV < 4 || DEAD_CYCLES >= DIV) begin : g_bad_params
            $error("seg7_scan_driver: need DIV >= 4 and DEAD_CYCLES < DIV");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_frame;
    logic             r_load_pending;
    logic [6:0]       r_seg;
    logic [3:0]       r_an;
    logic             r_frame_done;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_idx_nxt;
    logic [15:0]      w_frame_nxt;
    logic             w_pend_nxt;
    logic [6:0]       w_seg_nxt;
    logic [3:0]       w_an_nxt;
    logic             w_fd_nxt;
    logic             w_tick;
    logic [3:0]       w_nibble;
    logic             w_lz;
    logic [6:0]       w_dec;

    assign w_tick   = (r_cnt == CNT_LAST);
    assign w_nibble = r_frame[{r_idx, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
    // A digit is suppressed when it and every more-significant digit of the snapshot are zero.
    always_comb begin
        w_lz = 1'b0;
        case (r_idx)
            2'd1:    w_lz = (r_frame[15:4] == 12'h000);
            2'd2:    w_lz = (r_frame[15:8] == 8'h00);
            2'd3:    w_lz = (r_frame[15:12] == 4'h0);
            default: w_lz = 1'b0;
        endcase
    end
`else
    assign w_lz = 1'b0;
`endif

    // Active-low {g,f,e,d,c,b,a}; codes A..F give blank, "-", "C", "d", "E", "F".
    always_comb begin
        w_dec = 7'h7F;
        case (w_nibble)
            4'h0: w_dec = 7'b1000000;
            4'h1: w_dec = 7'b1111001;
            4'h2: w_dec = 7'b0100100;
            4'h3: w_dec = 7'b0110000;
            4'h4: w_dec = 7'b0011001;
            4'h5: w_dec = 7'b0010010;
            4'h6: w_dec = 7'b0000010;
            4'h7: w_dec = 7'b1111000;
            4'h8: w_dec = 7'b0000000;
            4'h9: w_dec = 7'b0010000;
            4'hA: w_dec = 7'b1111111;
            4'hB: w_dec = 7'b0111111;
            4'hC: w_dec = 7'b1000110;
            4'hD: w_dec = 7'b0100001;
            4'hE: w_dec = 7'b0000110;
            4'hF: w_dec = 7'b0001110;
            default: w_dec = 7'h7F;
        endcase
        if (w_lz) begin
            w_dec = 7'h7F;
        end
    end

    // Next-state and next-output logic; disabling parks the counter at 0 so a full slot follows.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_frame_nxt = r_frame;
        w_pend_nxt  = r_load_pending;
        w_seg_nxt   = 7'h7F;
        w_an_nxt    = 4'hF;
        w_fd_nxt    = 1'b0;
        if (enable) begin
            w_seg_nxt = w_dec;
            if (r_cnt >= CNT_DEAD) begin
                w_an_nxt = ~(4'b0001 << r_idx);
            end
            if (r_load_pending) begin
                w_frame_nxt = digits_in;
                w_pend_nxt  = 1'b0;
            end
            if (w_tick) begin
                w_cnt_nxt = '0;
                w_idx_nxt = r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    w_frame_nxt = digits_in;
                    w_fd_nxt    = 1'b1;
                end
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end else begin
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_idx          <= 2'd0;
            r_frame        <= 16'hAAAA;
            r_load_pending <= 1'b1;
            r_seg          <= 7'h7F;
            r_an           <= 4'hF;
            r_frame_done   <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_nxt;
            r_idx          <= w_idx_nxt;
            r_frame        <= w_frame_nxt;
            r_load_pending <= w_pend_nxt;
            r_seg          <= w_seg_nxt;
            r_an           <= w_an_nxt;
            r_frame_done   <= w_fd_nxt;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIV=10, DEAD_CYCLES=2) against a behavioural scan model.
module tb_seg7_scan_driver;

    localparam int DIV  = 10;
    localparam int DEAD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] digits_in;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: position within slot, digit index, snapshot, pending-load flag.
    int          m_pos;
    int          m_idx;
    logic [15:0] m_frame;
    bit          m_pend;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_fd;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .CLK_FREQ   (100),
        .SCAN_FREQ  (10),
        .DEAD_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits_in (digits_in),
        .enable    (enable),
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done)
    );

    // Build an active-low pattern from the list of lit segment letters.
    function automatic logic [6:0] pat(input string lit);
        logic [6:0] p;
        p = 7'h7F;
        for (int i = 0; i < lit.len(); i++) p[int'(lit[i]) - 97] = 1'b0;
        return p;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return pat("abcdef");
            4'h1: return pat("bc");
            4'h2: return pat("abdeg");
            4'h3: return pat("abcdg");
            4'h4: return pat("bcfg");
            4'h5: return pat("acdfg");
            4'h6: return pat("acdefg");
            4'h7: return pat("abc");
            4'h8: return pat("abcdefg");
            4'h9: return pat("abcdfg");
            4'hA: return pat("");
            4'hB: return pat("g");
            4'hC: return pat("adef");
            4'hD: return pat("bcdeg");
            4'hE: return pat("adefg");
            default: return pat("aefg");
        endcase
    endfunction

    function automatic logic [6:0] shown(input logic [15:0] f, input int i);
        logic [15:0] upper;
        upper = f >> (4 * i);
`ifdef SEG7_LZ_BLANK_EN
        if (i > 0 && upper == 16'h0000) return 7'h7F;
`endif
        return glyph(upper[3:0]);
    endfunction

    // Advance one clock and update the model with the inputs seen at that edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            exp_seg = 7'h7F; exp_an = 4'hF; exp_fd = 1'b0;
            m_pos = 0; m_idx = 0; m_frame = 16'hAAAA; m_pend = 1'b1;
        end else if (!enable) begin
            exp_seg = 7'h7F; exp_an = 4'hF; exp_fd = 1'b0;
            m_pos = 0;
        end else begin
            exp_seg = shown(m_frame, m_idx);
            exp_an  = 4'hF;
            if (m_pos >= DEAD) exp_an[m_idx] = 1'b0;
            exp_fd  = (m_pos == DIV - 1) && (m_idx == 3);
            if (m_pend) begin
                m_frame = digits_in;
                m_pend  = 1'b0;
            end
            if (m_pos == DIV - 1) begin
                if (m_idx == 3) m_frame = digits_in;
                m_idx = (m_idx + 1) % 4;
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        #1;
    endtask

    task automatic start(input logic [15:0] d);
        rst = 1'b1; enable = 1'b1; digits_in = d;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; digits_in = 16'h1234;
        repeat (3) begin
            step();
            n_checks++;
            if ({seg, an, frame_done} !== {7'h7F, 4'hF, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold: got seg=%h an=%h fd=%b want 7f f 0", seg, an, frame_done);
            end
        end
        rst = 1'b0;
        step();
        digits_in = 16'h9999;
        for (int k = 1; k < DIV; k++) begin
            step();
            n_checks++;
            if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                n_fail++;
                $display("FAIL reset_model k=%0d: got %h/%h/%b want %h/%h/%b", k, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
        n_checks++;
        if ({seg, an} !== {7'b0011001, 4'b1110}) begin
            n_fail++;
            $display("FAIL reset_first_load: got seg=%b an=%b want 0011001 1110", seg, an);
        end
    endtask

    task automatic test_scan_order();
        logic [3:0] want_an;
        int pulses;
        pulses = 0;
        start(16'h1234);
        for (int k = 0; k < 120; k++) begin
            step();
            want_an = 4'hF;
            if ((k % DIV) >= DEAD) want_an[(k / DIV) % 4] = 1'b0;
            n_checks++;
            if (an !== want_an || frame_done !== ((k % 40) == 39)) begin
                n_fail++;
                $display("FAIL scan_timing k=%0d: got an=%b fd=%b want an=%b fd=%b", k, an, frame_done, want_an, (k % 40) == 39);
            end
            if (frame_done === 1'b1) pulses++;
            if (k == 5 || k == 15) begin
                n_checks++;
                if (seg !== ((k == 5) ? 7'b0011001 : 7'b0110000)) begin
                    n_fail++;
                    $display("FAIL scan_glyph k=%0d: got %b", k, seg);
                end
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL scan_pulse_count: got %0d want 3", pulses);
        end
    endtask

    task automatic test_snapshot();
        start(16'h1234);
        for (int k = 0; k < 80; k++) begin
            step();
            if (k == 15) digits_in = 16'h5678;
            n_checks++;
            if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                n_fail++;
                $display("FAIL snapshot k=%0d: got %h/%h/%b want %h/%h/%b", k, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
            if (k == 25 || k == 35 || k == 45 || k == 75) begin
                n_checks++;
                if (seg !== ((k == 25) ? 7'b0100100 : (k == 35) ? 7'b1111001 :
                             (k == 45) ? 7'b0000000 : 7'b0010010)) begin
                    n_fail++;
                    $display("FAIL snapshot_glyph k=%0d: got %b", k, seg);
                end
            end
        end
    endtask

    task automatic test_blank();
        start(16'hAAAA);
        for (int k = 0; k < 40; k++) begin
            step();
            n_checks++;
            if (seg !== 7'h7F || an !== exp_an) begin
                n_fail++;
                $display("FAIL blank k=%0d: got seg=%h an=%b want 7f %b", k, seg, an, exp_an);
            end
        end
    endtask

    task automatic test_enable_freeze();
        int budget;
        start(16'h1234);
        repeat (26) step();
        enable = 1'b0;
        for (int j = 0; j < 15; j++) begin
            step();
            n_checks++;
            if ({seg, an, frame_done} !== {7'h7F, 4'hF, 1'b0}) begin
                n_fail++;
                $display("FAIL freeze_dark j=%0d: got %h/%h/%b want 7f/f/0", j, seg, an, frame_done);
            end
        end
        enable = 1'b1;
        for (int j = 0; j < DIV; j++) begin
            step();
            n_checks++;
            if (an !== ((j < DEAD) ? 4'hF : 4'b1011) || seg !== 7'b0100100) begin
                n_fail++;
                $display("FAIL freeze_resume j=%0d: got an=%b seg=%b", j, an, seg);
            end
        end
        budget = 0;
        while (frame_done !== 1'b1 && budget < 30) begin
            step();
            budget++;
        end
        n_checks++;
        if (frame_done !== 1'b1 || budget != DIV) begin
            n_fail++;
            $display("FAIL freeze_frame_done: got fd=%b after %0d cycles want 1 after %0d", frame_done, budget, DIV);
        end
    endtask

    task automatic test_lz();
        start(16'h0050);
        for (int k = 0; k < 40; k++) begin
            step();
            n_checks++;
            if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                n_fail++;
                $display("FAIL lz_model k=%0d: got %h/%h/%b want %h/%h/%b", k, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
            if (k == 15 || k == 25) begin
                n_checks++;
`ifdef SEG7_LZ_BLANK_EN
                if (seg !== ((k == 15) ? 7'b0010010 : 7'h7F)) begin
`else
                if (seg !== ((k == 15) ? 7'b0010010 : 7'b1000000)) begin
`endif
                    n_fail++;
                    $display("FAIL lz_glyph k=%0d: got %b", k, seg);
                end
            end
        end
        start(16'h0000);
        for (int k = 0; k < 40; k++) begin
            step();
            n_checks++;
            if (seg !== exp_seg || (k >= 1 && k < DIV && seg !== 7'b1000000)) begin
                n_fail++;
                $display("FAIL lz_zero k=%0d: got seg=%b want %b", k, seg, exp_seg);
            end
        end
    endtask

    task automatic test_midframe_reset();
        start(16'h1234);
        repeat (23) step();
        rst = 1'b1;
        step();
        n_checks++;
        if ({seg, an, frame_done} !== {7'h7F, 4'hF, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset: got %h/%h/%b want 7f/f/0", seg, an, frame_done);
        end
        rst = 1'b0; digits_in = 16'h4321;
        for (int k = 0; k < 20; k++) begin
            step();
            n_checks++;
            if ({seg, an} !== {exp_seg, exp_an} || (k == 5 && seg !== 7'b1111001)) begin
                n_fail++;
                $display("FAIL midreset_reload k=%0d: got %h/%h want %h/%h", k, seg, an, exp_seg, exp_an);
            end
        end
    endtask

    task automatic test_random();
        start(16'($urandom));
        for (int k = 0; k < 1500; k++) begin
            step();
            n_checks++;
            if ({seg, an, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                n_fail++;
                $display("FAIL random k=%0d: got %h/%h/%b want %h/%h/%b", k, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            end
            if ($urandom_range(0, 6) == 0) digits_in = 16'($urandom);
            enable = ($urandom_range(0, 11) != 0);
            rst    = ($urandom_range(0, 199) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; digits_in = 16'h0000;
        m_pos = 0; m_idx = 0; m_frame = 16'hAAAA; m_pend = 1'b1;
        exp_seg = 7'h7F; exp_an = 4'hF; exp_fd = 1'b0;
        test_reset();
        test_scan_order();
        test_snapshot();
        test_blank();
        test_enable_freeze();
        test_lz();
        test_midframe_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
